// File: rtl/sample_gain_stage.sv
// Volume/mute gain stage: scales signed samples by a 0..15 (x/8) gain, saturates, re-strobes.
// Define SAMPLE_GAIN_FADE_EN to build the per-sample fade-out/fade-in mute machine.
module sample_gain_stage #(
  parameter int unsigned FADE_STEP  = 64,
  parameter logic [3:0]  GAIN_RESET = 4'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        new_sample_in,
  input  logic        vol_up,
  input  logic        vol_down,
  input  logic        mute_toggle,
  output logic [15:0] sample_out,
  output logic        new_sample_out,
  output logic [3:0]  gain_level,
  output logic        muted
);

  if (FADE_STEP < 1) begin : g_bad_fade_step
    $error("FADE_STEP must be at least 1");
  end

`ifdef SAMPLE_GAIN_FADE_EN
  typedef enum logic [1:0] {StPlay, StFadeOut, StMuted, StFadeIn} state_e;
`else
  typedef enum logic [0:0] {StPlay, StMuted} state_e;
`endif

  state_e            state_q, state_d;
  logic [3:0]        gain_set_q, gain_set_d;
  logic [3:0]        gain_eff_q, gain_eff_d;
  logic              muted_q, muted_d;
  logic signed [20:0] prod_q, prod_d;
  logic signed [20:0] shr;
  logic              valid1_q;
  logic [15:0]       sample_out_q, sample_out_d;
  logic              new_out_q;

  always_comb begin
    gain_set_d = gain_set_q;
    if (vol_up && !vol_down && (gain_set_q != 4'd15)) begin
      gain_set_d = gain_set_q + 4'd1;
    end else if (vol_down && !vol_up && (gain_set_q != 4'd0)) begin
      gain_set_d = gain_set_q - 4'd1;
    end
  end

`ifdef SAMPLE_GAIN_FADE_EN
  localparam int unsigned CntW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fading, tick;

  assign fading = (state_q == StFadeOut) || (state_q == StFadeIn);
  assign tick   = fading && new_sample_in && (cnt_q == CntW'(FADE_STEP - 1));

  always_comb begin
    state_d    = state_q;
    gain_eff_d = gain_eff_q;
    case (state_q)
      StPlay: begin
        gain_eff_d = gain_set_q;
        if (mute_toggle) state_d = StFadeOut;
      end
      StFadeOut: begin
        if (mute_toggle) begin
          state_d = StFadeIn;
        end else if (gain_eff_q == 4'd0) begin
          state_d = StMuted;
        end else if (tick) begin
          gain_eff_d = gain_eff_q - 4'd1;
          if (gain_eff_q == 4'd1) state_d = StMuted;
        end
      end
      StMuted: begin
        gain_eff_d = 4'd0;
        if (mute_toggle) state_d = StFadeIn;
      end
      StFadeIn: begin
        if (mute_toggle) begin
          state_d = StFadeOut;
        end else if (gain_eff_q >= gain_set_q) begin
          // Covers gain_set lowered mid-fade and a zero gain_set on entry.
          gain_eff_d = gain_set_q;
          state_d    = StPlay;
        end else if (tick) begin
          gain_eff_d = gain_eff_q + 4'd1;
          if ((gain_eff_q + 4'd1) == gain_set_q) state_d = StPlay;
        end
      end
      default: state_d = StPlay;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || !fading) begin
      cnt_d = '0;
    end else if (new_sample_in) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  assign muted_d = (state_d == StFadeOut) || (state_d == StMuted);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  always_comb begin
    state_d    = state_q;
    gain_eff_d = gain_eff_q;
    case (state_q)
      StPlay: begin
        if (mute_toggle) begin
          state_d    = StMuted;
          gain_eff_d = 4'd0;
        end else begin
          gain_eff_d = gain_set_q;
        end
      end
      StMuted: begin
        if (mute_toggle) begin
          state_d    = StPlay;
          gain_eff_d = gain_set_q;
        end else begin
          gain_eff_d = 4'd0;
        end
      end
      default: state_d = StPlay;
    endcase
  end

  assign muted_d = (state_d == StMuted);
`endif

  // Gain is zero-extended so the multiply stays signed x non-negative.
  always_comb begin
    prod_d = prod_q;
    if (new_sample_in) begin
      prod_d = $signed({{5{sample_in[15]}}, sample_in}) * $signed({17'd0, gain_eff_q});
    end
  end

  assign shr = prod_q >>> 3;

  always_comb begin
    sample_out_d = sample_out_q;
    if (valid1_q) begin
      if (shr > 21'sd32767) begin
        sample_out_d = 16'h7fff;
      end else if (shr < -21'sd32768) begin
        sample_out_d = 16'h8000;
      end else begin
        sample_out_d = shr[15:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StPlay;
      gain_set_q   <= GAIN_RESET;
      gain_eff_q   <= GAIN_RESET;
      muted_q      <= 1'b0;
      prod_q       <= '0;
      valid1_q     <= 1'b0;
      sample_out_q <= '0;
      new_out_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gain_set_q   <= gain_set_d;
      gain_eff_q   <= gain_eff_d;
      muted_q      <= muted_d;
      prod_q       <= prod_d;
      valid1_q     <= new_sample_in;
      sample_out_q <= sample_out_d;
      new_out_q    <= valid1_q;
    end
  end

  assign sample_out     = sample_out_q;
  assign new_sample_out = new_out_q;
  assign gain_level     = gain_set_q;
  assign muted          = muted_q;

endmodule

// File: tb/tb_sample_gain_stage.sv
// Bench for sample_gain_stage: vector table for gain/saturation plus scoreboarded mute and
// reset sequences; fade checks are built when SAMPLE_GAIN_FADE_EN is defined.
module tb_sample_gain_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sample_in;
  logic        new_sample_in;
  logic        vol_up;
  logic        vol_down;
  logic        mute_toggle;
  logic [15:0] sample_out;
  logic        new_sample_out;
  logic [3:0]  gain_level;
  logic        muted;

  always #5 clk = ~clk;

  sample_gain_stage #(
    .FADE_STEP (4),
    .GAIN_RESET(4'd8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_in     (sample_in),
    .new_sample_in (new_sample_in),
    .vol_up        (vol_up),
    .vol_down      (vol_down),
    .mute_toggle   (mute_toggle),
    .sample_out    (sample_out),
    .new_sample_out(new_sample_out),
    .gain_level    (gain_level),
    .muted         (muted)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  typedef struct {
    int          ups;
    int          downs;
    logic [15:0] s;
    logic [15:0] exp_out;
    logic [3:0]  exp_gain;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: floor(s * g / 8) clamped to 16-bit signed.
  function automatic logic [15:0] scale(input logic [15:0] s, input int g);
    int p;
    p = int'($signed(s)) * g;
    p = p >>> 3;
    if (p > 32767) p = 32767;
    else if (p < -32768) p = -32768;
    return p[15:0];
  endfunction

  always @(negedge clk) begin
    if (!reset && new_sample_out) begin
      check("strobe_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("sample_out", {16'd0, sample_out}, {16'd0, mon_e.val});
        check("strobe_cycle", cyc, mon_e.due);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      new_sample_in = 1'b0;
      vol_up        = 1'b0;
      vol_down      = 1'b0;
      mute_toggle   = 1'b0;
    end
  endtask

  task automatic send(input logic [15:0] s, input logic [15:0] e, input bit push = 1'b1);
    @(posedge clk);
    #1;
    vol_up        = 1'b0;
    vol_down      = 1'b0;
    mute_toggle   = 1'b0;
    sample_in     = s;
    new_sample_in = 1'b1;
    if (push) sb.push_back(exp_t'{val: e, due: cyc + 2});
  endtask

  task automatic pulse(input bit up, input bit dn, input bit mt);
    @(posedge clk);
    #1;
    new_sample_in = 1'b0;
    vol_up        = up;
    vol_down      = dn;
    mute_toggle   = mt;
    idle(1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    idle(1);
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset         = 1'b1;
    new_sample_in = 1'b0;
    vol_up        = 1'b0;
    vol_down      = 1'b0;
    mute_toggle   = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_gain_level"}, gain_level, 4'd8);
    check({tag, "_muted"}, muted, 1'b0);
    check({tag, "_new_sample_out"}, new_sample_out, 1'b0);
  endtask

  // Outputs for a fade sequence: gain starts at g0, moves by dir every 4 strobes.
  task automatic fade_run(input int n, input int g0, input int dir);
    logic [15:0] s;
    for (int k = 0; k < n; k++) begin
      s = 16'($urandom);
      send(s, scale(s, g0 + dir * (k / 4)));
    end
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s;
    logic [15:0] last;
    int          seen;

    vecs[0]  = '{0, 0, 16'h1234, 16'h1234, 4'd8};
    vecs[1]  = '{0, 0, 16'h8000, 16'h8000, 4'd8};
    vecs[2]  = '{0, 0, 16'hffff, 16'hffff, 4'd8};
    vecs[3]  = '{7, 0, 16'h7000, 16'h7fff, 4'd15};
    vecs[4]  = '{0, 0, 16'h9000, 16'h8000, 4'd15};
    vecs[5]  = '{1, 0, 16'h0001, 16'h0001, 4'd15};
    vecs[6]  = '{0, 0, 16'hffff, 16'hfffe, 4'd15};
    vecs[7]  = '{0, 3, 16'h0003, 16'h0004, 4'd12};
    vecs[8]  = '{0, 0, 16'hfffd, 16'hfffb, 4'd12};
    vecs[9]  = '{0, 3, 16'h0100, 16'h0120, 4'd9};
    vecs[10] = '{0, 9, 16'h7fff, 16'h0000, 4'd0};
    vecs[11] = '{0, 1, 16'h8000, 16'h0000, 4'd0};
    vecs[12] = '{3, 0, 16'h0100, 16'h0060, 4'd3};
    vecs[13] = '{0, 0, 16'hf000, 16'hfa00, 4'd3};

    reset         = 1'b1;
    sample_in     = '0;
    new_sample_in = 1'b0;
    vol_up        = 1'b0;
    vol_down      = 1'b0;
    mute_toggle   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state("reset");
    check("reset_sample_out", sample_out, 16'h0000);

    for (int i = 0; i < 14; i++) begin
      repeat (vecs[i].ups) pulse(1'b1, 1'b0, 1'b0);
      repeat (vecs[i].downs) pulse(1'b0, 1'b1, 1'b0);
      idle(1);
      check($sformatf("gain_level_vec%0d", i), gain_level, vecs[i].exp_gain);
      send(vecs[i].s, vecs[i].exp_out);
      idle(1);
    end
    drain();

    pulse(1'b1, 1'b1, 1'b0);
    check("conflict_gain_level", gain_level, 4'd3);

    last = '0;
    for (int i = 0; i < 6; i++) begin
      s    = 16'($urandom);
      last = scale(s, 3);
      send(s, last);
    end
    drain();
    idle(3);
    check("hold_sample_out", sample_out, last);
    check("hold_no_strobe", new_sample_out, 1'b0);

    do_reset();
    check_reset_state("reset2");

`ifdef SAMPLE_GAIN_FADE_EN
    pulse(1'b0, 1'b0, 1'b1);
    check("fade_out_muted", muted, 1'b1);
    fade_run(32, 8, -1);
    check("muted_after_fade", muted, 1'b1);
    s = 16'h7fff;
    send(s, 16'h0000);
    drain();

    pulse(1'b0, 1'b0, 1'b1);
    check("fade_in_unmuted", muted, 1'b0);
    fade_run(32, 0, 1);
    s = 16'($urandom);
    send(s, scale(s, 8));
    drain();
    check("play_after_fade_in", muted, 1'b0);

    pulse(1'b0, 1'b0, 1'b1);
    fade_run(10, 8, -1);
    pulse(1'b0, 1'b0, 1'b1);
    check("reversal_unmuted", muted, 1'b0);
    fade_run(8, 6, 1);
    s = 16'($urandom);
    send(s, scale(s, 8));
    drain();

    pulse(1'b0, 1'b0, 1'b1);
    fade_run(32, 8, -1);
    pulse(1'b1, 1'b0, 1'b0);
    idle(2);
    check("muted_vol_up_gain", gain_level, 4'd9);
    check("muted_vol_up_muted", muted, 1'b1);
    s = 16'h4000;
    send(s, 16'h0000);
    drain();

    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    fade_run(3, 9, 0);
`else
    pulse(1'b0, 1'b0, 1'b1);
    check("mute_muted", muted, 1'b1);
    s = 16'h4000;
    send(s, 16'h0000);
    drain();
    pulse(1'b1, 1'b0, 1'b0);
    idle(2);
    check("muted_vol_up_gain", gain_level, 4'd9);
    s = 16'h7000;
    send(s, 16'h0000);
    drain();
    pulse(1'b0, 1'b0, 1'b1);
    check("unmute_muted", muted, 1'b0);
    s = 16'h0100;
    send(s, 16'h0120);
    drain();
`endif

    // Sample in flight when reset hits must never come out.
    send(16'h5555, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    new_sample_in = 1'b0;
    reset         = 1'b1;
    sb.delete();
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (new_sample_out) seen++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (new_sample_out) seen++;
    end
    check("no_strobe_after_reset", seen, 0);
    check_reset_state("reset3");
    send(16'h1234, 16'h1234);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_gain_stage.md
# sample_gain_stage

Digital volume and mute stage between the music player's sample output and its consumers: the codec headphone path and the wave display sample register. It scales each 16-bit signed sample by a user-selected gain level, saturates the result to 16 bits, and re-issues it with a one-cycle strobe. Mute uses an optional per-sample fade state machine. Volume and mute commands arrive as single-cycle pulses from the existing button press units.

## Interface
Parameters:
- `FADE_STEP`, default 64: number of `new_sample_in` strobes per one-step gain change while fading; legal range ≥ 1.
- `GAIN_RESET`, default 8: gain level after reset; 8 is unity gain.

Ports:
- `clk`  input  1: system clock (100 MHz domain).
- `reset`  input  1: asynchronous, active-high reset.
- `sample_in`  input  16: signed sample from the music player.
- `new_sample_in`  input  1: one-cycle strobe; `sample_in` is valid on this cycle.
- `vol_up`  input  1: one-cycle pulse that raises the set gain by 1.
- `vol_down`  input  1: one-cycle pulse that lowers the set gain by 1.
- `mute_toggle`  input  1: one-cycle pulse that toggles mute.
- `sample_out`  output  16: signed, scaled, saturated sample.
- `new_sample_out`  output  1: one-cycle strobe; `sample_out` is valid from this cycle onward.
- `gain_level`  output  4: current set gain, 0..15, intended for LEDs.
- `muted`  output  1: high in states FADE_OUT and MUTED.

## Operation
- Two gain registers:
  - `gain_set` is user-controlled. It saturates at 0 and 15. `vol_up` and `vol_down` asserted on the same cycle are ignored.
  - `gain_eff` is the gain actually applied.
- State machine, reset state PLAY:
  - PLAY: `gain_eff` = `gain_set`, tracking it on the cycle after every change. `mute_toggle` → FADE_OUT.
  - FADE_OUT: `gain_eff` decrements by 1 at each fade tick. Reaching 0 → MUTED. `mute_toggle` → FADE_IN, continuing from the current `gain_eff`.
  - MUTED: `gain_eff` = 0. `mute_toggle` → FADE_IN.
  - FADE_IN: `gain_eff` increments by 1 at each fade tick. Reaching `gain_set` → PLAY. `mute_toggle` → FADE_OUT.
    - If `gain_set` drops below `gain_eff` during FADE_IN, `gain_eff` is clamped to `gain_set` and the state goes to PLAY.
    - If `gain_set` is 0 on entry, FADE_IN → PLAY on the next cycle.
- Volume pulses change only `gain_set` while in FADE_OUT or MUTED.
- Fade tick counter:
  - Counts `new_sample_in` strobes from 0 to `FADE_STEP`-1; a tick fires on the strobe where the count equals `FADE_STEP`-1, and the counter then returns to 0.
  - Cleared on every state entry.
  - Idle in PLAY and MUTED.
- Arithmetic:
  - product = `sample_in` (signed 16) × {1'b0, `gain_eff`} (signed 5), giving a 21-bit signed value.
  - The product is arithmetic-shifted right by 3, giving an 18-bit value.
  - The result is saturated to [-32768, 32767]. Truncation is toward −∞; there is no rounding.
- `gain_eff` is sampled on the same cycle as `new_sample_in`. A gain change on that exact cycle applies to the next sample.

## Timing
- Pipeline depth is 2:
  - `new_sample_in` at cycle N: stage 1 registers the product at N+1.
  - Stage 2 registers the saturated `sample_out` and pulses `new_sample_out` at N+2, for exactly 1 cycle.
- `sample_out` holds its value between strobes.
- Back-to-back `new_sample_in` strobes on consecutive cycles are accepted at full rate.
- `gain_level` and `muted` are registered and update 1 cycle after the causing pulse or state change.
- Reset values: `sample_out` = 0, `new_sample_out` = 0, `gain_level` = `GAIN_RESET`, `muted` = 0, state PLAY, fade counter 0, pipeline valid bits 0.
- Reset asserted mid-fade or mid-pipeline discards in-flight samples; no strobe is emitted after reset.

## Configuration
- `SAMPLE_GAIN_FADE_EN`, when defined:
  - The full four-state fade machine is built as described above.
- When not defined:
  - `mute_toggle` switches directly between PLAY and MUTED.
  - `gain_eff` becomes 0 or `gain_set` on the next cycle.
  - FADE_OUT and FADE_IN are not built, and `FADE_STEP` is unused.
  - All other behaviour is unchanged.

## Test plan
- Unity pass-through: after reset, drive `sample_in` = 0x1234 with a strobe → `sample_out` = 0x1234 and `new_sample_out` high exactly 2 cycles later, for 1 cycle.
- Saturation: 7 `vol_up` pulses (gain 15), then `sample_in` = 0x7000 → `sample_out` = 0x7FFF; `sample_in` = 0x9000 → `sample_out` = 0x8000. An 8th `vol_up` leaves `gain_level` = 15.
- Floor and conflict:
  - 9 `vol_down` pulses → `gain_level` = 0, and any input gives `sample_out` = 0.
  - Simultaneous `vol_up`/`vol_down` → `gain_level` unchanged.
- Fade (macro defined, `FADE_STEP` = 4, gain 8):
  - `mute_toggle`, then strobes → `muted` = 1, and `gain_eff` steps down every 4 strobes; after 32 strobes, `sample_out` = 0 and the state is MUTED.
  - `mute_toggle` → gain returns to 8 after 32 strobes and `muted` = 0.
- Reversal and volume while muted:
  - `mute_toggle` after 10 strobes of FADE_OUT → FADE_IN from gain 6.
  - `vol_up` while MUTED → `gain_level` = 9, with output still 0.
- Reset mid-fade: assert `reset` during FADE_OUT with a sample in flight → no `new_sample_out` pulse, `gain_level` = 8, `muted` = 0; the next strobe passes at unity.
